// File: rtl/fsm_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : fsm_run_counter
// Purpose  : Run/done controller. A start pulse launches a run of N cycles
//            (N captured at start) followed by a one-cycle done pulse, with a
//            live cycle index, abort, and an optional auto-repeat loop mode.
// Revision : 1.0  initial release
// ============================================================================
module fsm_run_counter #(
  parameter int CNT_BIT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic               i_mode_loop,
  input  logic               i_abort,
  output logic               o_idle,
  output logic               o_running,
  output logic               o_done,
  output logic [CNT_BIT-1:0] o_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_BIT-1:0] c_cnt_one  = CNT_BIT'(1);
  localparam logic [CNT_BIT-1:0] c_cnt_zero = '0;

  state_t             r_state;
  logic [CNT_BIT-1:0] r_cnt;
  logic [CNT_BIT-1:0] r_num;
  logic               r_loop;
  logic               r_idle;
  logic               r_running;
  logic               r_done;
  logic               w_last;

  // Terminal compare: last cycle of the current pass. r_num is never 0
  // while running, so r_num-1 cannot underflow there.
  assign w_last = (r_cnt == (r_num - c_cnt_one));

  // State, counter, captured job parameters and the registered status
  // flags; flags are written together with the state they describe so
  // they always match the registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= c_cnt_zero;
      r_num     <= c_cnt_zero;
      r_loop    <= 1'b0;
      r_idle    <= 1'b1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A zero-length request is dropped rather than starting a run
          // that could never reach its terminal count.
          if (i_run && (i_num_cnt != c_cnt_zero)) begin
            r_state   <= S_RUN;
            r_num     <= i_num_cnt;
            r_loop    <= i_mode_loop;
            r_cnt     <= c_cnt_zero;
            r_idle    <= 1'b0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        S_RUN: begin
          // Abort is checked first so a collision with the terminal
          // count never produces a done pulse.
          if (i_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= c_cnt_zero;
            r_idle    <= 1'b1;
            r_running <= 1'b0;
            r_done    <= 1'b0;
          end else if (w_last) begin
            r_state   <= S_DONE;
            r_cnt     <= c_cnt_zero;
            r_idle    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + c_cnt_one;
          end
        end
        S_DONE: begin
          if (r_loop && !i_abort) begin
            r_state   <= S_RUN;
            r_cnt     <= c_cnt_zero;
            r_idle    <= 1'b0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end else begin
            r_state   <= S_IDLE;
            r_cnt     <= c_cnt_zero;
            r_idle    <= 1'b1;
            r_running <= 1'b0;
            r_done    <= 1'b0;
          end
        end
        default: begin
          // Unused encoding: fall back to idle on the next edge.
          r_state   <= S_IDLE;
          r_cnt     <= c_cnt_zero;
          r_idle    <= 1'b1;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_idle    = r_idle;
  assign o_running = r_running;
  assign o_done    = r_done;
  assign o_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fsm_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_run_counter
// Purpose  : Directed self-checking bench for fsm_run_counter (CNT_BIT=8).
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_fsm_run_counter;

  localparam int CNT_BIT = 8;

  logic               clk;
  logic               reset_n;
  logic               i_run;
  logic [CNT_BIT-1:0] i_num_cnt;
  logic               i_mode_loop;
  logic               i_abort;
  logic               o_idle;
  logic               o_running;
  logic               o_done;
  logic [CNT_BIT-1:0] o_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fsm_run_counter #(.CNT_BIT(CNT_BIT)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (i_run),
    .i_num_cnt   (i_num_cnt),
    .i_mode_loop (i_mode_loop),
    .i_abort     (i_abort),
    .o_idle      (o_idle),
    .o_running   (o_running),
    .o_done      (o_done),
    .o_cnt       (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (idle,run,done,cnt)", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic idle, input logic run,
                                       input logic done, input logic [CNT_BIT-1:0] cnt);
    return {21'b0, idle, run, done, cnt};
  endfunction

  task automatic chk_out(input string tag, input logic idle, input logic run,
                         input logic done, input int cnt);
    chk(tag, pack(o_idle, o_running, o_done, o_cnt), pack(idle, run, done, CNT_BIT'(cnt)));
  endtask

  // Issue a one-cycle start; returns on the falling edge after acceptance.
  task automatic start(input int n, input logic loop);
    i_run       = 1'b1;
    i_num_cnt   = CNT_BIT'(n);
    i_mode_loop = loop;
    @(negedge clk);
    i_run       = 1'b0;
  endtask

  // Full non-loop job: N running cycles with count 0..N-1, one done, idle.
  task automatic run_single(input string tag, input int n);
    start(n, 1'b0);
    for (int k = 0; k < n; k++) begin
      chk_out({tag, "_run"}, 1'b0, 1'b1, 1'b0, k);
      @(negedge clk);
    end
    chk_out({tag, "_done"}, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk_out({tag, "_idle"}, 1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    i_run       = 1'b0;
    i_num_cnt   = '0;
    i_mode_loop = 1'b0;
    i_abort     = 1'b0;

    // Power-on reset
    repeat (3) @(negedge clk);
    chk_out("por_hold", 1'b1, 1'b0, 1'b0, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_out("por_rel", 1'b1, 1'b0, 1'b0, 0);

    // Single runs including N=1 and the maximum length
    run_single("n5", 5);
    run_single("n1", 1);
    run_single("n255", 255);

    // Zero-length start is ignored
    start(0, 1'b0);
    chk_out("zero_a", 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk_out("zero_b", 1'b1, 1'b0, 1'b0, 0);

    // Restart pulse at cnt=2 with a different length is ignored
    start(5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk_out("rst_ign_run", 1'b0, 1'b1, 1'b0, k);
      if (k == 2) begin
        i_run     = 1'b1;
        i_num_cnt = 8'd2;
      end else begin
        i_run     = 1'b0;
      end
      @(negedge clk);
    end
    chk_out("rst_ign_done", 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk_out("rst_ign_idle", 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk_out("rst_ign_idle2", 1'b1, 1'b0, 1'b0, 0);

    // Loop mode N=3; loop input dropped after capture has no effect
    start(3, 1'b1);
    i_mode_loop = 1'b0;
    i_num_cnt   = 8'd7;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++) begin
        chk_out("loop_run", 1'b0, 1'b1, 1'b0, k);
        @(negedge clk);
      end
      chk_out("loop_done", 1'b0, 1'b0, 1'b1, 0);
      if (p == 3) i_abort = 1'b1;
      @(negedge clk);
    end
    i_abort = 1'b0;
    chk_out("loop_abort_idle", 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk_out("loop_abort_idle2", 1'b1, 1'b0, 1'b0, 0);

    // Abort colliding with the terminal count: no done pulse
    start(4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk_out("coll_run", 1'b0, 1'b1, 1'b0, k);
      if (k == 3) i_abort = 1'b1;
      @(negedge clk);
    end
    i_abort = 1'b0;
    chk_out("coll_idle", 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk_out("coll_idle2", 1'b1, 1'b0, 1'b0, 0);

    // Asynchronous reset mid-run, held for 10 cycles
    start(5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk_out("ar_run", 1'b0, 1'b1, 1'b0, k);
      if (k < 2) @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1 chk_out("ar_immediate", 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_out("ar_hold", 1'b1, 1'b0, 1'b0, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk_out("ar_rel", 1'b1, 1'b0, 1'b0, 0);
    run_single("ar_n2", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_run_counter.md
# fsm_run_counter

Parametrised run/done controller, the next generation of the team's single-shot IDLE/RUN/DONE FSM. A one-cycle start pulse launches a run of exactly `i_num_cnt` cycles, followed by a one-cycle done pulse. Adds a programmable run length, a live cycle count, an abort input and an auto-repeat (loop) mode. It sits between a host or sequencer issuing start pulses and a datapath that needs a fixed-length enable window.

## Interface
Parameters:
- `CNT_BIT`, 8: width of the run-length input and the cycle counter; maximum run length is 2^CNT_BIT-1.

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `i_run`  input  1  start request, sampled on `clk`; intended as a 1-cycle pulse.
- `i_num_cnt`  input  CNT_BIT  run length N, captured on accepted start.
- `i_mode_loop`  input  1  loop mode, captured on accepted start; 1 = auto-repeat.
- `i_abort`  input  1  cancel the current run/loop, sampled on `clk`.
- `o_idle`  output  1  high in S_IDLE.
- `o_running`  output  1  high in S_RUN.
- `o_done`  output  1  high for one cycle in S_DONE.
- `o_cnt`  output  CNT_BIT  cycle index within the current pass (0..N-1); 0 outside S_RUN.

## Operation
- States: S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10. 2'b11 is unreachable and recovers to S_IDLE on the next edge.
- Moore outputs, decoded from the registered state only. `o_cnt` is the counter register.
- S_IDLE:
  - `i_run`=1 with `i_num_cnt`!=0: capture N and the loop flag, clear the counter, go to S_RUN.
  - `i_run`=1 with `i_num_cnt`=0: ignored; stay in S_IDLE.
- S_RUN:
  - The counter increments every cycle.
  - When the counter equals N-1, go to S_DONE and clear the counter.
  - `i_abort`=1: go to S_IDLE and clear the counter. Abort beats completion when both occur on the same edge, so no `o_done` is produced.
- S_DONE:
  - Lasts exactly one cycle.
  - If the latched loop flag is set and `i_abort`=0, go to S_RUN with counter 0 and the same captured N.
  - Otherwise go to S_IDLE.
- `i_run` is ignored in S_RUN and S_DONE; no queuing, no restart.
- `i_num_cnt` and `i_mode_loop` changes after capture have no effect until the next accepted start.
- Counter never wraps: the terminal compare at N-1 fires before 2^CNT_BIT-1 is exceeded. N=2^CNT_BIT-1 is legal.
- Reset (asynchronous, any state, including mid-run):
  - state goes to S_IDLE; counter, captured N and loop flag go to 0.
  - Outputs: `o_idle`=1, `o_running`=0, `o_done`=0, `o_cnt`=0.
  - Operation resumes on the first rising edge after `reset_n` deasserts.

## Timing
- Start accepted at edge E: `o_running`=1 from E to E+N, with `o_cnt` = 0,1,..,N-1 in successive cycles.
- `o_done`=1 for the single cycle E+N..E+N+1.
- `o_idle`=1 again after edge E+N+1, or `o_running`=1 in loop mode.
- Start-to-done latency: N cycles. Total busy time per pass: N+1 cycles.
- Loop mode: each pass has the pattern N cycles RUN plus 1 cycle DONE, with no idle gap between passes.
- Abort: sampled at edge A, with `o_idle`=1 after A. Any count stops at its current value and is cleared at A.
- Earliest new start after return to S_IDLE: the very next edge, so back-to-back jobs have a 1-cycle idle gap.
- N=1: exactly one RUN cycle with `o_cnt`=0, then DONE.

## Test plan
- Reset check: hold `reset_n`=0 for 10 cycles mid-simulation, then release -> `o_idle`=1, `o_running`=0, `o_done`=0, `o_cnt`=0 during and after reset.
- Single run, N=5, loop=0: 1-cycle `i_run` -> `o_running` high 5 cycles with `o_cnt` 0..4, `o_done` high 1 cycle, then `o_idle`=1. Also run N=1, and N=255 with CNT_BIT=8, and check the same pattern.
- Zero / ignored starts: `i_run` with `i_num_cnt`=0 -> stays idle. `i_run` pulsed again at `o_cnt`=2 during an N=5 run -> run length unchanged at 5, a single `o_done`.
- Loop mode, N=3, loop=1: 3 passes observed -> `o_done` at cycles 3, 7 and 11 after the start. `i_abort` asserted in the 4th pass's S_DONE -> `o_idle`=1 next cycle, no further RUN.
- Abort collision: N=4, `i_abort` on the edge where `o_cnt`=3 -> S_IDLE, `o_done` never asserts. Separately, `reset_n` pulsed low during `o_cnt`=2 -> outputs cleared immediately (asynchronous), and a new N=2 start afterwards completes normally.
